// File: rtl/bank_sched_pkg.sv
// bank_sched_pkg: lock timing and op encoding shared by the bank scheduler.
package bank_sched_pkg;

    localparam int LOCK_W = 2;

    localparam logic [LOCK_W-1:0] WR_LOCK  = 2'd2;
    localparam logic [LOCK_W-1:0] RD_LOCK  = 2'd3;
    // Lock value one cycle before sense-amp enable, so the registered rsp_valid lines up with sa_en.
    localparam logic [LOCK_W-1:0] RSP_LOCK = RD_LOCK - 2'd1;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic logic [LOCK_W-1:0] lock_load(input op_e op);
        return (op == OP_WR) ? WR_LOCK : RD_LOCK;
    endfunction

endpackage

// File: rtl/bank_sched_arb.sv
// bank_sched_arb: one-hot grant plus encoded id from the eligible vector.
// RR_ARB_EN selects round-robin starting at rr_ptr; otherwise the lowest eligible index wins.
module bank_sched_arb #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
`ifdef RR_ARB_EN
    input  logic             clk,
    input  logic             rst_n,
`endif
    input  logic [N_REQ-1:0] i_elig,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_id
);

`ifdef RR_ARB_EN
    logic [ID_W-1:0] r_rr_ptr;
    logic            w_found;
    int              w_idx;

    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && i_elig[w_idx]) begin
                w_found = 1'b1;
                o_gnt   = N_REQ'(1) << w_idx;
                o_id    = ID_W'(w_idx);
            end
        end
    end

    // Any eligible requester is granted and handshakes, so the pointer advances on |i_elig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rr_ptr <= '0;
        else if (|i_elig)
            r_rr_ptr <= (int'(o_id) + 1 == N_REQ) ? '0 : o_id + 1'b1;
    end
`else
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_elig[k]) begin
                o_gnt = N_REQ'(1) << k;
                o_id  = ID_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/bank_sched.sv
// bank_sched: arbitrates requesters onto SRAM banks, issues w_en/r_en pulses, tracks bank locks
// and pending reads. Define RR_ARB_EN for round-robin arbitration (fixed priority otherwise).
module bank_sched
    import bank_sched_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int NUM_BANKS = 4,
    localparam int ID_W      = $clog2(N_REQ),
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*BANK_W-1:0] req_bank,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    gnt_valid,
    output logic [ID_W-1:0]         gnt_id,
    output logic [NUM_BANKS-1:0]    bank_w_en,
    output logic [NUM_BANKS-1:0]    bank_r_en,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [BANK_W-1:0]       rsp_bank
);

    logic [LOCK_W-1:0]    r_lock    [NUM_BANKS];
    logic [ID_W-1:0]      r_slot_id [NUM_BANKS];
    logic [NUM_BANKS-1:0] r_slot_vld;

    logic [N_REQ-1:0]     w_elig;
    logic [N_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]      w_id;
    logic [BANK_W-1:0]    w_bank;
    logic                 w_hs;
    op_e                  w_op;
    logic                 w_rsp_hit;
    logic [ID_W-1:0]      w_rsp_id;
    logic [BANK_W-1:0]    w_rsp_bank;

    // Out-of-range bank indices are never eligible when NUM_BANKS is not a power of two.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_valid[i]
                && ({1'b0, req_bank[i*BANK_W +: BANK_W]} < (BANK_W + 1)'(NUM_BANKS))
                && (r_lock[req_bank[i*BANK_W +: BANK_W]] == '0);
        end
    end

    bank_sched_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
`ifdef RR_ARB_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .i_elig (w_elig),
        .o_gnt  (w_gnt),
        .o_id   (w_id)
    );

    assign req_ready = w_gnt;
    assign w_hs      = |w_gnt;
    assign w_bank    = req_bank[int'(w_id)*BANK_W +: BANK_W];
    assign w_op      = op_e'(req_we[w_id]);

    always_comb begin
        w_rsp_hit  = 1'b0;
        w_rsp_id   = '0;
        w_rsp_bank = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_slot_vld[b] && r_lock[b] == RSP_LOCK) begin
                w_rsp_hit  = 1'b1;
                w_rsp_id   = r_slot_id[b];
                w_rsp_bank = BANK_W'(b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_vld <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_lock[b]    <= '0;
                r_slot_id[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_hs && w_bank == BANK_W'(b)) begin
                    r_lock[b]     <= lock_load(w_op);
                    r_slot_vld[b] <= (w_op == OP_RD);
                    r_slot_id[b]  <= w_id;
                end else begin
                    if (r_lock[b] != '0)
                        r_lock[b] <= r_lock[b] - 1'b1;
                    if (r_lock[b] == RSP_LOCK)
                        r_slot_vld[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            bank_w_en <= '0;
            bank_r_en <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_bank  <= '0;
        end else begin
            gnt_valid <= w_hs;
            gnt_id    <= w_id;
            bank_w_en <= (w_hs && w_op == OP_WR) ? NUM_BANKS'(1) << w_bank : '0;
            bank_r_en <= (w_hs && w_op == OP_RD) ? NUM_BANKS'(1) << w_bank : '0;
            rsp_valid <= w_rsp_hit;
            rsp_id    <= w_rsp_id;
            rsp_bank  <= w_rsp_bank;
        end
    end

endmodule

// File: tb/tb_bank_sched.sv
// tb_bank_sched: directed scenario tests for bank_sched with hand-computed expectations.
module tb_bank_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_valid = '0;
    logic [3:0] req_we = '0;
    logic [7:0] req_bank = '0;
    logic [3:0] req_ready;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic [3:0] bank_w_en;
    logic [3:0] bank_r_en;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [1:0] rsp_bank;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    bank_sched #(
        .N_REQ     (4),
        .NUM_BANKS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_bank  (req_bank),
        .req_ready (req_ready),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .bank_w_en (bank_w_en),
        .bank_r_en (bank_r_en),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_bank  (rsp_bank)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        logic [15:0] outs;
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_bank = '0;
        step(2);
        outs = {gnt_valid, gnt_id, bank_w_en, bank_r_en, rsp_valid, rsp_id, rsp_bank};
        n_chk++; if (outs !== 16'h0) begin n_err++; $display("FAIL rst_outs: got %h want 0", outs); end
        rst_n = 1'b1;
        step(1);
        req_valid = 4'b0010; req_we = 4'b0000; req_bank = 8'h04;
        step(1);
        n_chk++; if (bank_r_en !== 4'b0010) begin n_err++; $display("FAIL rst_pre_ren: got %b want 0010", bank_r_en); end
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        outs = {gnt_valid, gnt_id, bank_w_en, bank_r_en, rsp_valid, rsp_id, rsp_bank};
        n_chk++; if (outs !== 16'h0) begin n_err++; $display("FAIL rst_async: got %h want 0", outs); end
        step(1);
        outs = {gnt_valid, gnt_id, bank_w_en, bank_r_en, rsp_valid, rsp_id, rsp_bank};
        n_chk++; if (outs !== 16'h0) begin n_err++; $display("FAIL rst_held: got %h want 0", outs); end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1);
            n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_rsp[%0d]: got %b want 0", c, rsp_valid); end
        end
    endtask

    task automatic test_write;
        req_valid = 4'b0001; req_we = 4'b0001; req_bank = 8'h02;
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_ready_t: got %b want 0001", req_ready); end
        step(1);
        n_chk++; if (bank_w_en !== 4'b0100) begin n_err++; $display("FAIL wr_wen: got %b want 0100", bank_w_en); end
        n_chk++; if (bank_r_en !== 4'b0000) begin n_err++; $display("FAIL wr_ren: got %b want 0000", bank_r_en); end
        n_chk++; if ({gnt_valid, gnt_id} !== 3'b100) begin n_err++; $display("FAIL wr_gnt: got %b want 100", {gnt_valid, gnt_id}); end
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wr_ready_t1: got %b want 0000", req_ready); end
        step(1);
        n_chk++; if (bank_w_en !== 4'b0000) begin n_err++; $display("FAIL wr_wen_t2: got %b want 0000", bank_w_en); end
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wr_ready_t2: got %b want 0000", req_ready); end
        step(1);
        n_chk++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_ready_t3: got %b want 0001", req_ready); end
        req_valid = '0;
        step(4);
    endtask

    task automatic test_read;
        req_valid = 4'b0010; req_we = 4'b0000; req_bank = 8'h04;
        #1;
        n_chk++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_ready_t: got %b want 0010", req_ready); end
        step(1);
        n_chk++; if (bank_r_en !== 4'b0010) begin n_err++; $display("FAIL rd_ren: got %b want 0010", bank_r_en); end
        n_chk++; if ({gnt_valid, gnt_id} !== 3'b101) begin n_err++; $display("FAIL rd_gnt: got %b want 101", {gnt_valid, gnt_id}); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_t1: got %b want 0", rsp_valid); end
        step(1);
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_t2: got %b want 0", rsp_valid); end
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rd_ready_t2: got %b want 0000", req_ready); end
        step(1);
        n_chk++; if ({rsp_valid, rsp_id, rsp_bank} !== 5'b10101) begin n_err++; $display("FAIL rd_rsp_t3: got %b want 10101", {rsp_valid, rsp_id, rsp_bank}); end
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rd_ready_t3: got %b want 0000", req_ready); end
        step(1);
        n_chk++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_ready_t4: got %b want 0010", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_t4: got %b want 0", rsp_valid); end
        req_valid = '0;
        step(4);
    endtask

    task automatic test_idle;
        req_valid = '0;
        step(2);
        n_chk++; if ({gnt_valid, bank_w_en, bank_r_en, req_ready} !== 13'h0) begin n_err++; $display("FAIL idle_outs: got %h want 0", {gnt_valid, bank_w_en, bank_r_en, req_ready}); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        req_valid = 4'b1111; req_we = 4'b0000; req_bank = 8'hE4;
        for (int c = 0; c < 8; c++) begin
            if (c >= 1 && c <= 4) req_valid[c-1] = 1'b0;
            #1;
            if (c < 4) begin
                n_chk++; if (req_ready !== 4'(1 << c)) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << c)); end
            end
            if (c >= 1 && c <= 4) begin
                n_chk++; if ({gnt_valid, gnt_id} !== {1'b1, 2'(c-1)}) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, {gnt_valid, gnt_id}, {1'b1, 2'(c-1)}); end
                n_chk++; if (bank_r_en !== 4'(1 << (c-1))) begin n_err++; $display("FAIL b2b_ren[%0d]: got %b want %b", c, bank_r_en, 4'(1 << (c-1))); end
            end
            if (c >= 3 && c <= 6) begin
                n_chk++; if ({rsp_valid, rsp_id, rsp_bank} !== {1'b1, 2'(c-3), 2'(c-3)}) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %b want %b", c, {rsp_valid, rsp_id, rsp_bank}, {1'b1, 2'(c-3), 2'(c-3)}); end
            end else begin
                n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_norsp[%0d]: got %b want 0", c, rsp_valid); end
            end
            step(1);
        end
        req_valid = '0;
        step(4);
    endtask

    task automatic test_contention;
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        do_reset();
        req_valid = 4'b0101; req_we = 4'b0101; req_bank = 8'h00;
        for (int c = 0; c < 9; c++) begin
            #1;
`ifdef RR_ARB_EN
            exp_id = ((c / 3) % 2 == 1) ? 2'd2 : 2'd0;
`else
            exp_id = 2'd0;
`endif
            exp_rdy = (c % 3 == 0) ? 4'(1 << exp_id) : 4'b0000;
            n_chk++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL cont_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
            if (c % 3 == 1) begin
                n_chk++; if ({gnt_valid, gnt_id, bank_w_en} !== {1'b1, exp_id, 4'b0001}) begin n_err++; $display("FAIL cont_gnt[%0d]: got %b want %b", c, {gnt_valid, gnt_id, bank_w_en}, {1'b1, exp_id, 4'b0001}); end
            end
            step(1);
        end
        req_valid = '0;
        step(4);
    endtask

    task automatic test_wr_then_rd;
        do_reset();
        req_valid = 4'b0110; req_we = 4'b0010; req_bank = 8'h3C;
        #1;
        n_chk++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrd_ready_t: got %b want 0010", req_ready); end
        step(1);
        req_valid = 4'b0100;
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wrd_ready_t1: got %b want 0000", req_ready); end
        n_chk++; if ({bank_w_en, gnt_id} !== 6'b1000_01) begin n_err++; $display("FAIL wrd_wen: got %b want 100001", {bank_w_en, gnt_id}); end
        step(1);
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wrd_ready_t2: got %b want 0000", req_ready); end
        step(1);
        n_chk++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wrd_ready_t3: got %b want 0100", req_ready); end
        step(1);
        req_valid = '0;
        #1;
        n_chk++; if ({bank_r_en, gnt_id} !== 6'b1000_10) begin n_err++; $display("FAIL wrd_ren: got %b want 100010", {bank_r_en, gnt_id}); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wrd_rsp_t4: got %b want 0", rsp_valid); end
        step(2);
        n_chk++; if ({rsp_valid, rsp_id, rsp_bank} !== 5'b11011) begin n_err++; $display("FAIL wrd_rsp_t6: got %b want 11011", {rsp_valid, rsp_id, rsp_bank}); end
        step(3);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_idle();
        test_back_to_back();
        test_contention();
        test_wr_then_rd();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
